// File: rtl/ext_domain_pwr_seq.sv
// Per-domain power sequencer for external subsystems (switch, iso, reset, retention).
// Define EXT_DOMAIN_PWR_SEQ_IRQ_EN to enable the per-domain sequencing interrupt.
module ext_domain_pwr_seq #(
  parameter int unsigned NDOMAINS    = 2,
  parameter int unsigned ISO_CYCLES  = 4,
  parameter int unsigned RST_CYCLES  = 2,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NDOMAINS-1:0] pwr_req_i,
  input  logic [NDOMAINS-1:0] ret_req_i,
  input  logic [NDOMAINS-1:0] fault_clr_i,
  input  logic [NDOMAINS-1:0] switch_ack_i,
  output logic [NDOMAINS-1:0] switch_o,
  output logic [NDOMAINS-1:0] iso_o,
  output logic [NDOMAINS-1:0] rst_no,
  output logic [NDOMAINS-1:0] ret_o,
  output logic [NDOMAINS-1:0] ready_o,
  output logic [NDOMAINS-1:0] fault_o,
  output logic                irq_o,
  input  logic [NDOMAINS-1:0] irq_clr_i
);

  localparam bit TO_EN = (ACK_TIMEOUT != 0);
  localparam int unsigned TO_W =
    TO_EN ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam int unsigned SEQ_MAX =
    (ISO_CYCLES > RST_CYCLES) ? ISO_CYCLES : RST_CYCLES;
  localparam int unsigned SEQ_W = $clog2(SEQ_MAX + 1);

  localparam logic [TO_W-1:0] TO_LAST =
    TO_EN ? TO_W'(ACK_TIMEOUT - 1) : '0;
  localparam logic [SEQ_W-1:0] ISO_LD = SEQ_W'(ISO_CYCLES);
  localparam logic [SEQ_W-1:0] RST_LD = SEQ_W'(RST_CYCLES);
  localparam logic [SEQ_W-1:0] SEQ_ONE = SEQ_W'(1);

  typedef enum logic [2:0] {
    S_OFF,
    S_PWR_UP,
    S_ISO_REL,
    S_ON,
    S_RST_ASSERT,
    S_ISO_SET,
    S_PWR_DN,
    S_FAULT
  } state_e;

  state_e            st_q  [NDOMAINS];
  state_e            st_d  [NDOMAINS];
  logic [SEQ_W-1:0]  seq_q [NDOMAINS];
  logic [SEQ_W-1:0]  seq_d [NDOMAINS];
  logic [TO_W-1:0]   to_q  [NDOMAINS];
  logic [TO_W-1:0]   to_d  [NDOMAINS];

  logic [NDOMAINS-1:0] sync1_q, sync1_d;
  logic [NDOMAINS-1:0] ack_s_q, ack_s_d;
  logic [NDOMAINS-1:0] ret_req_q, ret_req_d;

  always_comb begin
    sync1_d   = switch_ack_i;
    ack_s_d   = sync1_q;
    ret_req_d = ret_req_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q   <= '0;
      ack_s_q   <= '0;
      ret_req_q <= '0;
      for (int d = 0; d < NDOMAINS; d++) begin
        st_q[d]  <= S_OFF;
        seq_q[d] <= '0;
        to_q[d]  <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      ack_s_q   <= ack_s_d;
      ret_req_q <= ret_req_d;
      for (int d = 0; d < NDOMAINS; d++) begin
        st_q[d]  <= st_d[d];
        seq_q[d] <= seq_d[d];
        to_q[d]  <= to_d[d];
      end
    end
  end

  // Requests are only honoured in OFF/ON so a started sequence always completes.
  always_comb begin
    for (int d = 0; d < NDOMAINS; d++) begin
      st_d[d]  = st_q[d];
      seq_d[d] = seq_q[d];
      to_d[d]  = to_q[d];
      case (st_q[d])
        S_OFF: begin
          if (pwr_req_i[d]) begin
            st_d[d] = S_PWR_UP;
            to_d[d] = '0;
          end
        end
        S_PWR_UP: begin
          if (TO_EN) to_d[d] = to_q[d] + 1'b1;
          if (ack_s_q[d]) begin
            st_d[d]  = S_ISO_REL;
            seq_d[d] = ISO_LD;
          end else if (TO_EN && to_q[d] == TO_LAST) begin
            st_d[d] = S_FAULT;
          end
        end
        S_ISO_REL: begin
          if (seq_q[d] == SEQ_ONE) st_d[d] = S_ON;
          else seq_d[d] = seq_q[d] - 1'b1;
        end
        S_ON: begin
          if (!pwr_req_i[d]) begin
            st_d[d]  = S_RST_ASSERT;
            seq_d[d] = RST_LD;
          end
        end
        S_RST_ASSERT: begin
          if (seq_q[d] == SEQ_ONE) begin
            st_d[d]  = S_ISO_SET;
            seq_d[d] = ISO_LD;
          end else begin
            seq_d[d] = seq_q[d] - 1'b1;
          end
        end
        S_ISO_SET: begin
          if (seq_q[d] == SEQ_ONE) begin
            st_d[d] = S_PWR_DN;
            to_d[d] = '0;
          end else begin
            seq_d[d] = seq_q[d] - 1'b1;
          end
        end
        S_PWR_DN: begin
          if (TO_EN) to_d[d] = to_q[d] + 1'b1;
          if (!ack_s_q[d]) begin
            st_d[d] = S_OFF;
          end else if (TO_EN && to_q[d] == TO_LAST) begin
            st_d[d] = S_FAULT;
          end
        end
        S_FAULT: begin
          if (fault_clr_i[d] && !pwr_req_i[d]) st_d[d] = S_OFF;
        end
        default: st_d[d] = S_OFF;
      endcase
    end
  end

  always_comb begin
    switch_o = '0;
    iso_o    = '1;
    rst_no   = '0;
    ret_o    = '0;
    ready_o  = '0;
    fault_o  = '0;
    for (int d = 0; d < NDOMAINS; d++) begin
      case (st_q[d])
        S_OFF: ret_o[d] = ret_req_q[d];
        S_PWR_UP: switch_o[d] = 1'b1;
        S_ISO_REL: begin
          switch_o[d] = 1'b1;
          iso_o[d]    = 1'b0;
        end
        S_ON: begin
          switch_o[d] = 1'b1;
          iso_o[d]    = 1'b0;
          rst_no[d]   = 1'b1;
          ready_o[d]  = 1'b1;
        end
        S_RST_ASSERT: begin
          switch_o[d] = 1'b1;
          iso_o[d]    = 1'b0;
        end
        S_ISO_SET: switch_o[d] = 1'b1;
        S_PWR_DN: ret_o[d] = ret_req_q[d];
        S_FAULT: fault_o[d] = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef EXT_DOMAIN_PWR_SEQ_IRQ_EN
  logic [NDOMAINS-1:0] ent_q, ent_d;
  logic [NDOMAINS-1:0] pend_q, pend_d;
  logic                irq_q, irq_d;

  // Reset clears ent_q, so the reset-forced OFF never raises a pending bit.
  always_comb begin
    for (int d = 0; d < NDOMAINS; d++) begin
      ent_d[d] = (st_d[d] != st_q[d]) &&
                 (st_d[d] inside {S_OFF, S_ON, S_FAULT});
    end
    pend_d = ent_q | (pend_q & ~irq_clr_i);
    irq_d  = |pend_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ent_q  <= '0;
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      ent_q  <= ent_d;
      pend_q <= pend_d;
      irq_q  <= irq_d;
    end
  end

  assign irq_o = irq_q;
`else
  logic unused_irq_clr;
  assign unused_irq_clr = ^irq_clr_i;
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_ext_domain_pwr_seq.sv
// Directed bench for ext_domain_pwr_seq with a timeline-based reference model.
module tb_ext_domain_pwr_seq;
  localparam int N   = 2;
  localparam int ISO = 4;
  localparam int RST = 2;
  localparam int TO  = 64;

  localparam int M_OFF = 0;
  localparam int M_UP  = 1;
  localparam int M_ON  = 2;
  localparam int M_DN  = 3;
  localparam int M_FLT = 4;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic [N-1:0] pwr_req_i = '0;
  logic [N-1:0] ret_req_i = '0;
  logic [N-1:0] fault_clr_i = '0;
  logic [N-1:0] switch_ack_i = '0;
  logic [N-1:0] irq_clr_i = '0;
  logic [N-1:0] switch_o, iso_o, rst_no, ret_o, ready_o, fault_o;
  logic irq_o;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  ext_domain_pwr_seq #(
    .NDOMAINS(N), .ISO_CYCLES(ISO), .RST_CYCLES(RST), .ACK_TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .pwr_req_i(pwr_req_i), .ret_req_i(ret_req_i),
    .fault_clr_i(fault_clr_i), .switch_ack_i(switch_ack_i),
    .switch_o(switch_o), .iso_o(iso_o), .rst_no(rst_no),
    .ret_o(ret_o), .ready_o(ready_o), .fault_o(fault_o),
    .irq_o(irq_o), .irq_clr_i(irq_clr_i)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // Model: mode plus the cycle each phase began; outputs follow from elapsed time.
  int mode [N] = '{default: 0};
  int t0   [N] = '{default: 0};
  int ta   [N] = '{default: 0};
  logic [N-1:0] s1_m = '0, acks_m = '0, retr_m = '0;
  logic [N-1:0] ent_m = '0, pend_m = '0;
  logic irq_m = 1'b0;

  always @(negedge clk) begin
    logic [N-1:0] e_sw, e_iso, e_rst, e_ret, e_rdy, e_flt, ent_n;
    logic e_irq;
    int k, nm;
    for (int d = 0; d < N; d++) begin
      k = cyc - t0[d];
      e_sw[d] = 0; e_iso[d] = 1; e_rst[d] = 0;
      e_rdy[d] = 0; e_flt[d] = 0; e_ret[d] = 0;
      case (mode[d])
        M_OFF: e_ret[d] = retr_m[d];
        M_UP: begin
          e_sw[d] = 1;
          e_iso[d] = (ta[d] == 0);
        end
        M_ON: begin
          e_sw[d] = 1; e_iso[d] = 0; e_rst[d] = 1; e_rdy[d] = 1;
        end
        M_DN: begin
          if (k < RST) begin
            e_sw[d] = 1; e_iso[d] = 0;
          end else if (k < RST + ISO) begin
            e_sw[d] = 1;
          end else begin
            e_ret[d] = retr_m[d];
          end
        end
        default: e_flt[d] = 1;
      endcase
    end
`ifdef EXT_DOMAIN_PWR_SEQ_IRQ_EN
    e_irq = irq_m;
`else
    e_irq = 1'b0;
`endif
    cmp("switch_o", 16'(switch_o), 16'(e_sw));
    cmp("iso_o", 16'(iso_o), 16'(e_iso));
    cmp("rst_no", 16'(rst_no), 16'(e_rst));
    cmp("ret_o", 16'(ret_o), 16'(e_ret));
    cmp("ready_o", 16'(ready_o), 16'(e_rdy));
    cmp("fault_o", 16'(fault_o), 16'(e_flt));
    cmp("irq_o", 16'(irq_o), 16'(e_irq));

    if (!rst_ni) begin
      for (int d = 0; d < N; d++) begin
        mode[d] = M_OFF; t0[d] = cyc + 1; ta[d] = 0;
      end
      s1_m = '0; acks_m = '0; retr_m = '0;
      ent_m = '0; pend_m = '0; irq_m = 1'b0;
    end else begin
      ent_n = '0;
      for (int d = 0; d < N; d++) begin
        nm = mode[d];
        k = cyc - t0[d];
        case (mode[d])
          M_OFF: if (pwr_req_i[d]) begin nm = M_UP; ta[d] = 0; end
          M_UP: begin
            if (ta[d] == 0) begin
              if (acks_m[d]) ta[d] = cyc + 1;
              else if (TO != 0 && cyc + 1 - t0[d] == TO) nm = M_FLT;
            end else if (cyc + 1 - ta[d] == ISO) begin
              nm = M_ON;
            end
          end
          M_ON: if (!pwr_req_i[d]) nm = M_DN;
          M_DN: begin
            if (k >= RST + ISO) begin
              if (!acks_m[d]) nm = M_OFF;
              else if (TO != 0 && cyc + 1 - (t0[d] + RST + ISO) == TO)
                nm = M_FLT;
            end
          end
          default: if (fault_clr_i[d] && !pwr_req_i[d]) nm = M_OFF;
        endcase
        if (nm != mode[d]) begin
          t0[d] = cyc + 1;
          mode[d] = nm;
          ent_n[d] = (nm == M_OFF || nm == M_ON || nm == M_FLT);
        end
      end
      irq_m = |pend_m;
      pend_m = ent_m | (pend_m & ~irq_clr_i);
      ent_m = ent_n;
      acks_m = s1_m;
      s1_m = switch_ack_i;
      retr_m = ret_req_i;
    end
    cyc++;
  end

  task automatic goto(input int n);
    while (cyc != n) @(posedge clk);
    #1;
  endtask

  task automatic bit_chk(input string nm, input logic act, input logic exp);
    cmp(nm, 16'(act), 16'(exp));
  endtask

  initial begin
    goto(2);  rst_ni = 1'b1;
    goto(10); bit_chk("up_sw0_c10", switch_o[0], 1'b0); pwr_req_i[0] = 1'b1;
    goto(11); bit_chk("up_sw0_c11", switch_o[0], 1'b1);
              bit_chk("up_iso0_c11", iso_o[0], 1'b1);
    goto(12); pwr_req_i[1] = 1'b1;
    goto(13); switch_ack_i[0] = 1'b1;
    goto(14); switch_ack_i[1] = 1'b1;
    goto(15); bit_chk("up_iso0_c15", iso_o[0], 1'b1);
    goto(16); bit_chk("up_iso0_c16", iso_o[0], 1'b0);
              bit_chk("up_rst0_c16", rst_no[0], 1'b0);
    goto(19); bit_chk("up_iso0_c19", iso_o[0], 1'b0);
              bit_chk("up_rdy0_c19", ready_o[0], 1'b0);
    goto(20); bit_chk("up_rdy0_c20", ready_o[0], 1'b1);
              bit_chk("up_rst0_c20", rst_no[0], 1'b1);
    goto(21); bit_chk("up_rdy1_c21", ready_o[1], 1'b1);
`ifdef EXT_DOMAIN_PWR_SEQ_IRQ_EN
              bit_chk("irq_c21", irq_o, 1'b0);
`endif
    goto(22);
`ifdef EXT_DOMAIN_PWR_SEQ_IRQ_EN
              bit_chk("irq_c22", irq_o, 1'b1);
`else
              bit_chk("irq_off_c22", irq_o, 1'b0);
`endif
    goto(24); irq_clr_i = 2'b11;
    goto(25); irq_clr_i = 2'b00;
`ifdef EXT_DOMAIN_PWR_SEQ_IRQ_EN
              bit_chk("irq_c25", irq_o, 1'b1);
`endif
    goto(26);
`ifdef EXT_DOMAIN_PWR_SEQ_IRQ_EN
              bit_chk("irq_clr_c26", irq_o, 1'b0);
`endif
    goto(30); bit_chk("dn_rdy0_c30", ready_o[0], 1'b1); pwr_req_i[0] = 1'b0;
    goto(31); bit_chk("dn_rst0_c31", rst_no[0], 1'b0);
              bit_chk("dn_iso0_c31", iso_o[0], 1'b0);
              bit_chk("dn_sw0_c31", switch_o[0], 1'b1);
    goto(32); bit_chk("dn_rst0_c32", rst_no[0], 1'b0);
    goto(33); bit_chk("dn_iso0_c33", iso_o[0], 1'b1); ret_req_i[0] = 1'b1;
    goto(36); bit_chk("dn_ret0_c36", ret_o[0], 1'b0);
              bit_chk("dn_sw0_c36", switch_o[0], 1'b1);
    goto(37); bit_chk("dn_sw0_c37", switch_o[0], 1'b0);
              bit_chk("dn_ret0_c37", ret_o[0], 1'b1);
    goto(38); switch_ack_i[0] = 1'b0;
    goto(40); pwr_req_i[0] = 1'b1;
    goto(41); bit_chk("off_sw0_c41", switch_o[0], 1'b0);
    goto(42); bit_chk("re_sw0_c42", switch_o[0], 1'b1);
              bit_chk("re_ret0_c42", ret_o[0], 1'b0);
              ret_req_i[0] = 1'b0;
    goto(44); switch_ack_i[0] = 1'b1; pwr_req_i[1] = 1'b0;
    goto(47); pwr_req_i[0] = 1'b0;
              bit_chk("ind_iso1_c47", iso_o[1], 1'b1);
              bit_chk("ind_iso0_c47", iso_o[0], 1'b0);
    goto(49); pwr_req_i[0] = 1'b1;
    goto(50); bit_chk("tog_iso0_c50", iso_o[0], 1'b0);
    goto(51); bit_chk("tog_rdy0_c51", ready_o[0], 1'b1);
              bit_chk("ind_sw1_c51", switch_o[1], 1'b0);
    goto(52); switch_ack_i[1] = 1'b0;
    goto(60); pwr_req_i[1] = 1'b1;
    goto(124); bit_chk("to_flt1_c124", fault_o[1], 1'b0);
               bit_chk("to_sw1_c124", switch_o[1], 1'b1);
    goto(125); bit_chk("to_flt1_c125", fault_o[1], 1'b1);
               bit_chk("to_sw1_c125", switch_o[1], 1'b0);
    goto(130); fault_clr_i[1] = 1'b1;
    goto(131); fault_clr_i[1] = 1'b0;
               bit_chk("clr_ign_c131", fault_o[1], 1'b1);
    goto(132); pwr_req_i[1] = 1'b0;
    goto(134); fault_clr_i[1] = 1'b1;
               bit_chk("clr_flt1_c134", fault_o[1], 1'b1);
    goto(135); fault_clr_i[1] = 1'b0;
               bit_chk("clr_flt1_c135", fault_o[1], 1'b0);
    goto(140); pwr_req_i[0] = 1'b0;
    goto(147); switch_ack_i[0] = 1'b0;
    goto(152); pwr_req_i[0] = 1'b1;
    goto(153); switch_ack_i[0] = 1'b1;
    goto(157); bit_chk("mid_iso0_c157", iso_o[0], 1'b0); rst_ni = 1'b0;
    goto(158); rst_ni = 1'b1;
               cmp("rst_sw_c158", 16'(switch_o), 16'h0);
               cmp("rst_iso_c158", 16'(iso_o), 16'h3);
               cmp("rst_rstn_c158", 16'(rst_no), 16'h0);
               cmp("rst_rdy_c158", 16'(ready_o), 16'h0);
               cmp("rst_flt_c158", 16'(fault_o), 16'h0);
               bit_chk("rst_irq_c158", irq_o, 1'b0);
    goto(165); bit_chk("post_rdy0_c165", ready_o[0], 1'b1);
    goto(170);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    fails++;
    $display("FAIL watchdog cyc=%0d got=running want=done", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ext_domain_pwr_seq.md
Name: ext_domain_pwr_seq

Overview:
- Parametrised power sequencer for NDOMAINS external subsystem power domains, e.g. CGRA and future accelerators.
- Replaces the fixed single-domain hookup of switch, isolation, reset and retention with one independent FSM per domain.
- Sits between the accelerator top level and the external power switches, isolation cells and domain reset/retention inputs.
- Adds handshaked power-up/down, ack timeout with fault state, and per-domain status.

Parameters:
- NDOMAINS, 2, number of independently sequenced external domains (1..16).
- ISO_CYCLES, 4, cycles iso_o stays in its new state before the next step (>=1).
- RST_CYCLES, 2, cycles rst_no is held low before isolation on power-down (>=1).
- ACK_TIMEOUT, 64, cycles allowed for switch ack; 0 disables the timeout.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- pwr_req_i  in  NDOMAINS  level: 1 = domain requested on.
- ret_req_i  in  NDOMAINS  level: 1 = request RAM retention while off.
- fault_clr_i  in  NDOMAINS  pulse: clears FAULT for that domain.
- switch_ack_i  in  NDOMAINS  asynchronous ack from power switch; follows switch_o.
- switch_o  out  NDOMAINS  1 = power switch closed (domain powered).
- iso_o  out  NDOMAINS  1 = outputs isolated.
- rst_no  out  NDOMAINS  domain logic reset, active-low.
- ret_o  out  NDOMAINS  1 = RAM banks retentive.
- ready_o  out  NDOMAINS  1 = domain in ON.
- fault_o  out  NDOMAINS  1 = domain in FAULT.
- irq_o  out  1  sequencing interrupt (see Optional Feature).
- irq_clr_i  in  NDOMAINS  pulse: clears pending irq bit.

Behaviour:
- Reset, synchronous on rst_ni=0 at clk_i edge. All FSMs go to OFF and all counters clear. Outputs: switch_o=0, iso_o=all 1, rst_no=0, ret_o=0, ready_o=0, fault_o=0, irq_o=0. Sync flops clear to 0.
- Reset mid-sequence is immediate and has the same result: switch opens without a drain.
- switch_ack_i is resynchronised per bit with a 2-flop synchroniser into ack_s. An edge on the input is visible in ack_s 2 cycles later.
- All outputs are Moore-decoded from registered state, with no combinational paths from inputs.
- Per-domain states and outputs (switch, iso, rst_no, ready, fault):
  - OFF: 0,1,0,0,0. If pwr_req=1 -> PWR_UP next cycle.
  - PWR_UP: 1,1,0,0,0. If ack_s=1 -> ISO_REL. If the timeout counter reaches ACK_TIMEOUT -> FAULT.
  - ISO_REL: 1,0,0,0,0. After ISO_CYCLES cycles -> ON.
  - ON: 1,0,1,1,0. If pwr_req=0 -> RST_ASSERT.
  - RST_ASSERT: 1,0,0,0,0. After RST_CYCLES cycles -> ISO_SET.
  - ISO_SET: 1,1,0,0,0. After ISO_CYCLES cycles -> PWR_DN.
  - PWR_DN: 0,1,0,0,0. If ack_s=0 -> OFF. If the timeout counter reaches ACK_TIMEOUT -> FAULT.
  - FAULT: 0,1,0,0,1. If fault_clr=1 and pwr_req=0 -> OFF. A clear with pwr_req=1 is ignored.
- pwr_req_i is sampled only in OFF and ON. Changes during transitional states are ignored until a stable state is reached, so no sequence is aborted.
- Timeout counter:
  - Width $clog2(ACK_TIMEOUT+1).
  - Clears on entry to PWR_UP/PWR_DN and increments each cycle in those states.
  - The fault takes effect the cycle the counter equals ACK_TIMEOUT with ack_s not yet valid.
  - If ack_s arrives in that same cycle, ack wins.
- ISO/RST counters are a single shared-width down-counter per domain, loaded on state entry and exiting at 1. A state lasts exactly N cycles.
- ret_o = ret_req_i registered, but only in OFF or PWR_DN; forced to 0 in every other state.
- Domains are fully independent; simultaneous events on different domains do not interact.

Optional Feature:
- Macro: EXT_DOMAIN_PWR_SEQ_IRQ_EN.
- When defined:
  - Each domain has a pending bit, set on the cycle after entry to ON, OFF (except after reset) or FAULT.
  - irq_clr_i[d] clears the bit; on a same-cycle set and clear, set wins.
  - irq_o = registered OR of the pending bits, one cycle later.
- When undefined: no pending flops, irq_o tied 0, irq_clr_i unused.

Test Plan:
- Power-up: pwr_req[0]=1 at cycle 10; ack[0] rises at cycle 13 -> switch_o[0]=1 from 11, ack_s at 15, iso_o[0]=0 at 16–19, rst_no[0]=ready_o[0]=1 at 20.
- Power-down: ON domain, pwr_req[0]=0 at cycle 30 -> rst_no=0 at 31–32, iso_o=1 from 33, switch_o=0 at 37; ack falls at 38 -> OFF at 41.
- Timeout: pwr_req[1]=1, ack held 0 -> fault_o[1]=1 exactly 64 cycles after PWR_UP entry, switch_o[1]=0. fault_clr with pwr_req=1 ignored; with pwr_req=0 -> OFF.
- Independence/mid-change: domain 0 up while domain 1 goes down with overlapping timing -> both follow their own timelines. Toggling pwr_req[0] during ISO_REL has no effect.
- Reset mid-sequence: rst_ni=0 for one cycle while in ISO_REL -> next cycle all outputs at reset values, FSM in OFF.
- IRQ (macro on): domain reaches ON -> irq_o=1 two cycles after ON entry. irq_clr_i[0] pulse -> irq_o=0 two cycles later. Macro off -> irq_o constant 0.
